// File: rtl/dmem_pipe_ctrl.sv
// Y86-64 data-memory stage: decodes icode into a load/store, range/alignment
// checks the address, and runs the access with a fixed latency behind a busy/done handshake.
module dmem_pipe_ctrl #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1,
  parameter bit ALIGN_CHECK   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  icode,
  input  logic [63:0] val_A,
  input  logic [63:0] val_E,
  input  logic [63:0] val_P,
  output logic [63:0] val_M,
  output logic        busy,
  output logic        done,
  output logic        dmem_er
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(8 * DEPTH_WORDS - 8);
  localparam logic [3:0]  RD_CNT   = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  WR_CNT   = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_t;

  state_t             state_r, state_s;
  op_t                op_r, dec_op_s;
  logic [3:0]         cnt_r, cnt_s;
  logic [IDX_W-1:0]   idx_r;
  logic [63:0]        wdata_r;
  logic [63:0]        val_m_r;
  logic               busy_r, done_r, er_r;
  logic [63:0]        dec_addr_s, dec_data_s;
  logic               bad_addr_s, illegal_s, accept_s;
  logic [63:0]        mem_r [DEPTH_WORDS];

  assign val_M   = val_m_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign dmem_er = er_r;

  // Operation decode: which operand is the address and which is the store data.
  always_comb begin
    dec_op_s   = OP_NOP;
    dec_addr_s = val_E;
    dec_data_s = val_A;
    case (icode)
      4'd5: begin
        dec_op_s   = OP_LOAD;
        dec_addr_s = val_E;
      end
      4'd9, 4'd11: begin
        dec_op_s   = OP_LOAD;
        dec_addr_s = val_A;
      end
      4'd4, 4'd10: begin
        dec_op_s   = OP_STORE;
        dec_addr_s = val_E;
        dec_data_s = val_A;
      end
      4'd8: begin
        dec_op_s   = OP_STORE;
        dec_addr_s = val_E;
        dec_data_s = val_P;
      end
      default: begin
        dec_op_s = OP_NOP;
      end
    endcase
  end

  // Address legality; only real loads/stores can be illegal.
  always_comb begin
    bad_addr_s = dec_addr_s[63] || (dec_addr_s > MAX_ADDR) ||
                 (ALIGN_CHECK && (dec_addr_s[2:0] != 3'd0));
    if (dec_op_s != OP_NOP) begin
      illegal_s = bad_addr_s;
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Next-state logic: errors and NOPs take the one-cycle path straight to RESP.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          accept_s = 1'b1;
          if (illegal_s || (dec_op_s == OP_NOP)) begin
            cnt_s   = 4'd0;
            state_s = ST_RESP;
          end else if (dec_op_s == OP_LOAD) begin
            cnt_s   = RD_CNT;
            state_s = (RD_CNT == 4'd0) ? ST_RESP : ST_ACCESS;
          end else begin
            cnt_s   = WR_CNT;
            state_s = (WR_CNT == 4'd0) ? ST_RESP : ST_ACCESS;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, handshake outputs, latched request and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      op_r    <= OP_NOP;
      idx_r   <= '0;
      wdata_r <= 64'd0;
      val_m_r <= 64'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      er_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_RESP);
      if (accept_s) begin
        op_r    <= illegal_s ? OP_NOP : dec_op_s;
        idx_r   <= dec_addr_s[IDX_W+2:3];
        wdata_r <= dec_data_s;
        if (illegal_s) begin
          er_r <= 1'b1;
        end
      end
      if ((state_r == ST_RESP) && (op_r == OP_LOAD)) begin
        val_m_r <= mem_r[idx_r];
      end
    end
  end

  // Storage array is never cleared; a reset in the RESP cycle suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_RESP) && (op_r == OP_STORE)) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_dmem_pipe_ctrl.sv
// Scoreboard bench for dmem_pipe_ctrl: three instances (default, no alignment
// check, long latencies) driven by directed and random accesses against a word-level model.
module tb_dmem_pipe_ctrl;

  typedef struct {
    int          lat;
    longint      acc;
    logic [63:0] valm;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  reset, req, busy, done, dmem_er;
  logic [3:0]  icode [3];
  logic [63:0] val_a [3];
  logic [63:0] val_e [3];
  logic [63:0] val_p [3];
  logic [63:0] val_m [3];

  longint      cyc = 0;
  int          checks = 0;
  int          passed = 0;
  exp_t        exp_q [3][$];
  int          issued [3];
  int          done_cnt [3];
  int          busy_cnt [3];
  bit          chk_pend [3];
  logic [63:0] chk_val [3];

  logic [63:0] mdl_mem [3][1024];
  logic [63:0] valm_mdl [3];
  bit          er_mdl [3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_pipe_ctrl #(
      .DEPTH_WORDS  (1024),
      .READ_LATENCY ((g == 2) ? 4 : 2),
      .WRITE_LATENCY((g == 2) ? 3 : 1),
      .ALIGN_CHECK  ((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk    (clk),
      .reset  (reset[g]),
      .req    (req[g]),
      .icode  (icode[g]),
      .val_A  (val_a[g]),
      .val_E  (val_e[g]),
      .val_P  (val_p[g]),
      .val_M  (val_m[g]),
      .busy   (busy[g]),
      .done   (done[g]),
      .dmem_er(dmem_er[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Reference model: word-addressed memory, sticky error, held load result.
  function automatic void model(input int g, input logic [3:0] ic, input logic [63:0] va,
                                input logic [63:0] ve, input logic [63:0] vp, output exp_t e);
    bit ld, st, bad;
    longint a;
    logic [63:0] d;
    ld = (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
    st = (ic == 4'd4) || (ic == 4'd8) || (ic == 4'd10);
    a = (ic == 4'd9 || ic == 4'd11) ? longint'(va) : longint'(ve);
    d = (ic == 4'd8) ? vp : va;
    bad = (ld || st) && ((a < 0) || (a > longint'(8 * 1024 - 8)) || ((g != 1) && (a % 8 != 0)));
    e.lat = 1;
    if (bad) begin
      er_mdl[g] = 1'b1;
    end else if (st) begin
      mdl_mem[g][int'(a / 8)] = d;
      e.lat = (g == 2) ? 3 : 1;
    end else if (ld) begin
      valm_mdl[g] = mdl_mem[g][int'(a / 8)];
      e.lat = (g == 2) ? 4 : 2;
    end
    e.valm = valm_mdl[g];
    e.er   = er_mdl[g];
    e.acc  = 0;
  endfunction

  task automatic issue(input int g, input logic [3:0] ic, input logic [63:0] va,
                       input logic [63:0] ve, input logic [63:0] vp, input bit hold);
    exp_t e;
    int n;
    model(g, ic, va, ve, vp, e);
    @(negedge clk);
    icode[g] = ic;
    val_a[g] = va;
    val_e[g] = ve;
    val_p[g] = vp;
    req[g]   = 1'b1;
    e.acc    = cyc;
    exp_q[g].push_back(e);
    issued[g]++;
    @(negedge clk);
    if (hold) begin
      val_e[g] = 64'h80;
      val_a[g] = ~va;
    end else begin
      req[g] = 1'b0;
    end
    n = 0;
    while (!done[g] && n < 40) begin
      @(negedge clk);
      n++;
    end
    req[g] = 1'b0;
    if (!done[g]) check($sformatf("done_timeout_i%0d", g), {63'd0, done[g]}, 64'd1);
  endtask

  // Monitor: pops the scoreboard on every done and checks latency, busy span, error, val_M.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (chk_pend[g]) begin
        check($sformatf("val_M_i%0d", g), val_m[g], chk_val[g]);
        chk_pend[g] = 1'b0;
      end
      if (!busy[g]) busy_cnt[g] = 0;
      else busy_cnt[g]++;
      if (done[g]) begin
        done_cnt[g]++;
        check($sformatf("done_expected_i%0d", g), 64'(exp_q[g].size() > 0), 64'd1);
        if (exp_q[g].size() > 0) begin
          e = exp_q[g].pop_front();
          check($sformatf("latency_i%0d", g), 64'(cyc - e.acc), 64'(e.lat));
          check($sformatf("busy_cycles_i%0d", g), 64'(busy_cnt[g]), 64'(e.lat));
          check($sformatf("dmem_er_i%0d", g), {63'd0, dmem_er[g]}, {63'd0, e.er});
          chk_pend[g] = 1'b1;
          chk_val[g]  = e.valm;
        end
      end
    end
  end

  task automatic rand_ops(input int g, input int cnt);
    logic [63:0] addr, d1, d2;
    logic [3:0]  ic;
    int k, w;
    logic [3:0] ics [6] = '{4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    repeat (cnt) begin
      k = $urandom_range(0, 9);
      w = $urandom_range(0, 15);
      case (k)
        0, 1, 2, 3, 4, 5: addr = 64'(w * 8);
        6:       addr = 64'h1FF8;
        7:       addr = 64'(w * 8 + 4);
        8:       addr = 64'hFFFF_FFFF_FFFF_FFF8;
        default: addr = ($urandom_range(0, 1) == 0) ? 64'h2000 : 64'h4000_0000_0000_0000;
      endcase
      k  = $urandom_range(0, 7);
      ic = (k < 6) ? ics[k] : 4'($urandom_range(0, 15));
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      if (ic == 4'd9 || ic == 4'd11) issue(g, ic, addr, d1, d2, 1'b0);
      else issue(g, ic, d1, addr, d2, 1'b0);
    end
  endtask

  task automatic init_words(input int g);
    for (int w = 0; w < 16; w++) issue(g, 4'd4, {$urandom, $urandom}, 64'(w * 8), 64'd0, 1'b0);
    issue(g, 4'd4, {$urandom, $urandom}, 64'h1FF8, 64'd0, 1'b0);
  endtask

  task automatic run0;
    issue(0, 4'd4, 64'h1122334455667788, 64'h40, 64'd0, 1'b0);
    issue(0, 4'd5, 64'd0, 64'h40, 64'd0, 1'b0);
    issue(0, 4'd8, 64'd0, 64'h1FF8, 64'h123, 1'b0);
    issue(0, 4'd9, 64'h1FF8, 64'd0, 64'd0, 1'b0);
    issue(0, 4'd0, 64'h40, 64'h40, 64'd0, 1'b0);
    issue(0, 4'd4, 64'hA5A5_0000_0000_5A5A, 64'h0, 64'd0, 1'b0);
    issue(0, 4'd5, 64'd0, 64'h2000, 64'd0, 1'b0);
    issue(0, 4'd11, 64'h40, 64'd0, 64'd0, 1'b0);
    issue(0, 4'd10, 64'hDEAD_BEEF_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0);
    issue(0, 4'd5, 64'd0, 64'h0, 64'd0, 1'b0);
    issue(0, 4'd5, 64'd0, 64'h44, 64'd0, 1'b0);
    init_words(0);
    rand_ops(0, 60);
  endtask

  task automatic run1;
    issue(1, 4'd4, 64'h0BAD_F00D_1234_5678, 64'h40, 64'd0, 1'b0);
    issue(1, 4'd5, 64'd0, 64'h44, 64'd0, 1'b0);
    init_words(1);
    rand_ops(1, 60);
  endtask

  task automatic run2;
    issue(2, 4'd4, 64'h2020_2020_2020_2020, 64'h20, 64'd0, 1'b0);
    issue(2, 4'd4, 64'h8080_8080_8080_8080, 64'h80, 64'd0, 1'b0);
    issue(2, 4'd5, 64'd0, 64'h20, 64'd0, 1'b1);
    issue(2, 4'd10, 64'h0000_0000_0000_2222, 64'h10, 64'd0, 1'b0);
    issue(2, 4'd5, 64'd0, 64'h2000, 64'd0, 1'b0);
    @(negedge clk);
    icode[2] = 4'd10;
    val_a[2] = 64'hFFFF_0000_FFFF_0000;
    val_e[2] = 64'h10;
    req[2]   = 1'b1;
    @(negedge clk);
    req[2]   = 1'b0;
    reset[2] = 1'b1;
    @(negedge clk);
    reset[2]    = 1'b0;
    er_mdl[2]   = 1'b0;
    valm_mdl[2] = 64'd0;
    check("abort_busy", {63'd0, busy[2]}, 64'd0);
    check("abort_done", {63'd0, done[2]}, 64'd0);
    check("abort_dmem_er", {63'd0, dmem_er[2]}, 64'd0);
    check("abort_val_M", val_m[2], 64'd0);
    repeat (6) @(negedge clk);
    issue(2, 4'd5, 64'd0, 64'h10, 64'd0, 1'b0);
    init_words(2);
    rand_ops(2, 40);
  endtask

  initial begin
    reset = 3'b111;
    req   = 3'b000;
    for (int g = 0; g < 3; g++) begin
      icode[g] = 4'd0;
      val_a[g] = 64'd0;
      val_e[g] = 64'd0;
      val_p[g] = 64'd0;
      valm_mdl[g] = 64'd0;
      er_mdl[g]   = 1'b0;
      issued[g]   = 0;
      done_cnt[g] = 0;
      busy_cnt[g] = 0;
      chk_pend[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_busy_i%0d", g), {63'd0, busy[g]}, 64'd0);
      check($sformatf("reset_done_i%0d", g), {63'd0, done[g]}, 64'd0);
      check($sformatf("reset_er_i%0d", g), {63'd0, dmem_er[g]}, 64'd0);
      check($sformatf("reset_val_M_i%0d", g), val_m[g], 64'd0);
    end
    reset = 3'b000;
    fork
      run0;
      run1;
      run2;
    join
    repeat (4) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("done_count_i%0d", g), 64'(done_cnt[g]), 64'(issued[g]));
      check($sformatf("queue_drained_i%0d", g), 64'(exp_q[g].size()), 64'd0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
